// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word datapath.
package serial_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int unsigned SER_WIDTH = 8;

endpackage

// File: rtl/s2p_bit_counter.sv
// Bit counter for serial-to-parallel framing: counts 0..WIDTH-1, then wraps to 0.
module s2p_bit_counter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic Clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    assign tc_c = (count == LAST);

    // Clear wins over enable; terminal count wraps back to zero.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tc_c) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Collects an LSB-first bit-serial frame into a parallel word and offers it
// on a valid/ready handshake, flagging words dropped under backpressure.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             start,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             data_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    state_t           state;
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] full_word_c;
    logic             shift_c;
    logic             last_bit_c;

    // Only the upper WIDTH-1 bits are kept; the oldest bit would fall off anyway.
    assign full_word_c = {serial_in, shreg};
    assign shift_c     = (state == COLLECT) && shift_en && !start;

    s2p_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .Clock (Clock),
        .reset (reset),
        .clr   (start),
        .en    (shift_c),
        .tc_c  (last_bit_c)
    );

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                        shreg <= '0;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        shreg <= '0;
                    end else if (shift_en) begin
                        shreg <= full_word_c[WIDTH-1:1];
                        if (last_bit_c) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A completed word may replace one being consumed this edge.
                            if (!data_valid || data_ready) begin
                                data_out   <= full_word_c;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed, table-driven bench for serial_word_collector (WIDTH = 8).
module tb_serial_word_collector;

    logic       Clock = 1'b0;
    logic       reset;
    logic       start;
    logic       serial_in;
    logic       shift_en;
    logic       data_ready;
    logic       ovr_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;

    serial_word_collector #(
        .WIDTH (8)
    ) dut (
        .Clock      (Clock),
        .reset      (reset),
        .start      (start),
        .serial_in  (serial_in),
        .shift_en   (shift_en),
        .data_ready (data_ready),
        .ovr_clr    (ovr_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       st;
        logic       si;
        logic       se;
        logic       rd;
        logic       cl;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic si, input logic se, input logic rd,
                       input logic cl, input logic ev, input logic [7:0] ed,
                       input logic eb, input logic eo);
        vec_t v;
        v.st = st; v.si = si; v.se = se; v.rd = rd; v.cl = cl;
        v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
        vq.push_back(v);
    endtask

    // Start row plus one frame; mid-frame rows expect the held (hv,hd,ho) output state.
    task automatic add_frame(input logic [7:0] w, input bit gaps,
                             input logic hv, input logic [7:0] hd, input logic ho,
                             input logic rl, input logic cl,
                             input logic ev, input logic [7:0] ed, input logic eo);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hv, hd, 1'b1, ho);
        for (int i = 0; i < 8; i++) begin
            if (gaps) add(1'b0, ~w[i], 1'b0, 1'b0, 1'b0, hv, hd, 1'b1, ho);
            if (i < 7) add(1'b0, w[i], 1'b1, 1'b0, 1'b0, hv, hd, 1'b1, ho);
            else       add(1'b0, w[i], 1'b1, rl, cl, ev, ed, 1'b0, eo);
        end
    endtask

    task automatic run_rows(input string tag);
        for (int r = 0; r < vq.size(); r++) begin
            start      = vq[r].st;
            serial_in  = vq[r].si;
            shift_en   = vq[r].se;
            data_ready = vq[r].rd;
            ovr_clr    = vq[r].cl;
            @(posedge Clock);
            #1;
            chk({tag, ".data_valid"}, r, 8'(data_valid), 8'(vq[r].ev));
            chk({tag, ".data_out"},   r, data_out,       vq[r].ed);
            chk({tag, ".busy"},       r, 8'(busy),       8'(vq[r].eb));
            chk({tag, ".overrun"},    r, 8'(overrun),    8'(vq[r].eo));
        end
        start = 1'b0; shift_en = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] w;

        reset = 1'b1; start = 1'b0; serial_in = 1'b0;
        shift_en = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
        #12;
        chk("reset.data_valid", 0, 8'(data_valid), 8'h00);
        chk("reset.data_out",   0, data_out,       8'h00);
        chk("reset.busy",       0, 8'(busy),       8'h00);
        chk("reset.overrun",    0, 8'(overrun),    8'h00);
        @(negedge Clock);
        reset = 1'b0;
        @(posedge Clock);
        #1;

        // IDLE ignores shift_en; data_ready without valid is a no-op
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        // contiguous 0xF6, then consume
        add_frame(8'hF6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF6, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF6, 1'b0, 1'b0);
        // 0xF6 with gaps (inverted junk on serial_in during gaps)
        add_frame(8'hF6, 1'b1, 1'b0, 8'hF6, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF6, 1'b0);
        // backpressure: 0x5A dropped, overrun set, then cleared
        add_frame(8'h5A, 1'b0, 1'b1, 8'hF6, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF6, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF6, 1'b0, 1'b0);
        // consume and complete on the same edge: new word replaces the old one
        add_frame(8'h5A, 1'b0, 1'b1, 8'hF6, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        // restart after 5 bits, then full 0x81
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
        add_frame(8'h81, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        // start on the completing edge discards the word, then 0xC3 arrives
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
        w = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) add(1'b0, w[i], 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
            else       add(1'b0, w[i], 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        end
        // overrun set and clear on the same edge: set wins
        add_frame(8'h11, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        run_rows("table");

        // mid-frame asynchronous reset, then a clean 0x3C frame
        vq.delete();
        w = 8'h3C;
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, w[i], 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
        run_rows("prereset");
        #2 reset = 1'b1;
        #1;
        chk("midreset.data_valid", 0, 8'(data_valid), 8'h00);
        chk("midreset.data_out",   0, data_out,       8'h00);
        chk("midreset.busy",       0, 8'(busy),       8'h00);
        chk("midreset.overrun",    0, 8'(overrun),    8'h00);
        #1 reset = 1'b0;
        @(posedge Clock);
        #1;
        vq.delete();
        add_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        run_rows("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
